// File: rtl/channel_commutator_if.sv
// Bus bundle between the per-channel input buffers, the commutator and
// the serializer-facing output. The slave modport is the commutator's view.
interface channel_commutator_if #(
    parameter int CHANNELS   = 3,
    parameter int DATA_WIDTH = 8,
    parameter int CW         = $clog2(CHANNELS)
);
    logic                           enable;
    logic                           priority_mode;
    logic [CHANNELS-1:0]            input_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] input_data;
    logic [CHANNELS-1:0]            read_req;
    logic [DATA_WIDTH-1:0]          output_data;
    logic                           output_valid;
    logic                           output_sof;
    logic [CW-1:0]                  active_channel;

    modport master (
        output enable,
        output priority_mode,
        output input_ready,
        output input_data,
        input  read_req,
        input  output_data,
        input  output_valid,
        input  output_sof,
        input  active_channel
    );

    modport slave (
        input  enable,
        input  priority_mode,
        input  input_ready,
        input  input_data,
        output read_req,
        output output_data,
        output output_valid,
        output output_sof,
        output active_channel
    );
endinterface

// File: rtl/channel_commutator.sv
// Channel commutator: arbitrates among CHANNELS input buffers (round-robin
// or fixed priority), pops BURST words from the granted buffer and emits a
// framed packet (header word with channel id, then payload). Idle fill words
// are emitted whenever no header/payload beat is in flight.
module channel_commutator #(
    parameter int         CHANNELS   = 3,
    parameter int         DATA_WIDTH = 8,
    parameter int         BURST      = 4,
    parameter logic [7:0] IDLE_WORD  = 8'hBC
) (
    input logic                 clk,
    input logic                 arst,
    channel_commutator_if.slave bus
);
    localparam int          CW        = $clog2(CHANNELS);
    localparam logic [CW:0] CH_EXT    = (CW+1)'(CHANNELS);
    localparam logic [7:0]  LAST_BEAT = 8'(BURST - 1);

    typedef enum logic {S_IDLE, S_READ} state_t;
    typedef enum logic [1:0] {B_NONE, B_HDR, B_PAY} beat_t;

    // FSM / request side
    state_t              r_state, w_state_next;
    logic [7:0]          r_cnt, w_cnt_next;
    logic [CHANNELS-1:0] r_read_req, w_read_req_next;
    logic [CW-1:0]       r_active, w_active_next;
    logic [CW-1:0]       r_last_grant, w_last_grant_next;

    // Stage 1: beat type and owning channel of the beat in flight
    beat_t               r_s1_beat, w_s1_beat_next;
    logic [CW-1:0]       r_s1_ch, w_s1_ch_next;

    // Stage 2: registered outputs
    logic [DATA_WIDTH-1:0] r_out_data, w_out_data_next;
    logic                  r_out_valid, w_out_valid_next;
    logic                  r_out_sof, w_out_sof_next;

    // Arbiter results
    logic          w_grant_found;
    logic [CW-1:0] w_grant_ch;
    logic [CW:0]   w_idx;

    // Per-channel payload slices of the input bus
    logic [DATA_WIDTH-1:0] w_slice [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slice
            assign w_slice[gi] = bus.input_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Arbiter: iterate in reverse search order so the last hit is the winner
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_ch    = '0;
        w_idx         = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            if (bus.priority_mode) begin
                w_idx = (CW+1)'(i - 1);
            end else begin
                w_idx = {1'b0, r_last_grant} + (CW+1)'(i);
                if (w_idx >= CH_EXT) begin
                    w_idx = w_idx - CH_EXT;
                end
            end
            if (bus.input_ready[w_idx[CW-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_ch    = w_idx[CW-1:0];
            end
        end
    end

    // Next-state logic: grant in IDLE, count the burst in READ
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_read_req_next   = r_read_req;
        w_active_next     = r_active;
        w_last_grant_next = r_last_grant;
        w_s1_beat_next    = B_NONE;
        w_s1_ch_next      = r_active;
        case (r_state)
            S_IDLE: begin
                w_read_req_next = '0;
                if (bus.enable && w_grant_found) begin
                    w_state_next      = S_READ;
                    w_cnt_next        = '0;
                    w_read_req_next   = CHANNELS'(1) << w_grant_ch;
                    w_active_next     = w_grant_ch;
                    w_last_grant_next = w_grant_ch;
                    w_s1_beat_next    = B_HDR;
                    w_s1_ch_next      = w_grant_ch;
                end
            end
            S_READ: begin
                // The request visible this cycle yields a payload word next cycle
                w_s1_beat_next = B_PAY;
                w_s1_ch_next   = r_active;
                if (r_cnt == LAST_BEAT) begin
                    w_state_next    = S_IDLE;
                    w_read_req_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next    = S_IDLE;
                w_read_req_next = '0;
            end
        endcase
    end

    // Output word formation; payload uses the channel recorded with the beat
    always_comb begin
        w_out_data_next  = '0;
        w_out_valid_next = 1'b0;
        w_out_sof_next   = 1'b0;
        case (r_s1_beat)
            B_HDR: begin
                w_out_data_next[DATA_WIDTH-1 -: 4] = 4'hA;
                w_out_data_next[CW-1:0]            = r_s1_ch;
                w_out_valid_next                   = 1'b1;
                w_out_sof_next                     = 1'b1;
            end
            B_PAY: begin
                w_out_data_next  = w_slice[r_s1_ch];
                w_out_valid_next = 1'b1;
            end
            default: begin
                w_out_data_next[7:0] = IDLE_WORD;
            end
        endcase
    end

    // State and pipeline registers; reset abandons any packet in flight
    always_ff @(posedge clk) begin
        if (arst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_read_req   <= '0;
            r_active     <= '0;
            r_last_grant <= CW'(CHANNELS - 1);
            r_s1_beat    <= B_NONE;
            r_s1_ch      <= '0;
            r_out_data   <= DATA_WIDTH'(IDLE_WORD);
            r_out_valid  <= 1'b0;
            r_out_sof    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_read_req   <= w_read_req_next;
            r_active     <= w_active_next;
            r_last_grant <= w_last_grant_next;
            r_s1_beat    <= w_s1_beat_next;
            r_s1_ch      <= w_s1_ch_next;
            r_out_data   <= w_out_data_next;
            r_out_valid  <= w_out_valid_next;
            r_out_sof    <= w_out_sof_next;
        end
    end

    assign bus.read_req       = r_read_req;
    assign bus.active_channel = r_active;
    assign bus.output_data    = r_out_data;
    assign bus.output_valid   = r_out_valid;
    assign bus.output_sof     = r_out_sof;
endmodule

// File: tb/tb_channel_commutator.sv
// Testbench for channel_commutator (CHANNELS=3, BURST=4, 8-bit words).
// Buffer i returns 0x10*(i+1)+n for its n-th pop; expected packets are
// queued per scenario and compared beat by beat.
module tb_channel_commutator;
    logic clk = 1'b0;
    logic arst = 1'b1;

    always #5 clk = ~clk;

    channel_commutator_if #(.CHANNELS(3), .DATA_WIDTH(8)) bus ();

    channel_commutator #(
        .CHANNELS(3), .DATA_WIDTH(8), .BURST(4), .IDLE_WORD(8'hBC)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] sb_q [$];   // {sof, data}
    int buf_cnt [3];

    // Input buffer model: word for a pop is valid the cycle after read_req
    always @(posedge clk) begin
        if (arst) begin
            for (int i = 0; i < 3; i++) buf_cnt[i] <= 0;
            bus.input_data <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bus.read_req[i]) begin
                    bus.input_data[i*8 +: 8] <= 8'(16 * (i + 1) + buf_cnt[i]);
                    buf_cnt[i] <= buf_cnt[i] + 1;
                end
            end
        end
    end

    task automatic push_pkt(input int ch, input int n0);
        sb_q.push_back({1'b1, 8'(160 + ch)});
        for (int k = 0; k < 4; k++) sb_q.push_back({1'b0, 8'(16 * (ch + 1) + n0 + k)});
    endtask

    task automatic do_reset();
        arst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.priority_mode = 1'b0;
        bus.input_ready = 3'b000;
        arst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.output_data, bus.output_valid, bus.output_sof, bus.read_req, bus.active_channel}
            !== {8'hBC, 1'b0, 1'b0, 3'b000, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_values: got data=%h v=%b sof=%b rr=%b act=%0d expected data=bc v=0 sof=0 rr=000 act=0",
                     bus.output_data, bus.output_valid, bus.output_sof, bus.read_req, bus.active_channel);
        end
        arst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if ({bus.output_data, bus.output_valid, bus.read_req} !== {8'hBC, 1'b0, 3'b000}) begin
                miscompares++;
                $display("FAIL idle_fill cyc %0d: got data=%h v=%b rr=%b expected data=bc v=0 rr=000",
                         c, bus.output_data, bus.output_valid, bus.read_req);
            end
        end
    endtask

    // Consume the whole scoreboard as one contiguous run of valid beats
    task automatic consume_contiguous(input string name, input int ready_switch_at,
                                      input logic [2:0] new_ready);
        int w = 0;
        int beat = 0;
        logic [8:0] e;
        while (!bus.output_valid && w < 12) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (!bus.output_valid) begin
            miscompares++;
            $display("FAIL %s_start: got no valid beat within %0d cycles, expected a header", name, w);
            sb_q.delete();
        end
        while (sb_q.size() > 0) begin
            if (beat == ready_switch_at) bus.input_ready = new_ready;
            e = sb_q.pop_front();
            vectors++;
            if ({bus.output_valid, bus.output_sof, bus.output_data} !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL %s_beat %0d: got v=%b sof=%b data=%h expected v=1 sof=%b data=%h",
                         name, beat, bus.output_valid, bus.output_sof, bus.output_data, e[8], e[7:0]);
            end
            beat++;
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        bus.enable = 1'b1;
        bus.priority_mode = 1'b0;
        bus.input_ready = 3'b111;
        do_reset();
        sb_q.delete();
        push_pkt(0, 0);
        push_pkt(1, 0);
        push_pkt(2, 0);
        push_pkt(0, 4);
        consume_contiguous("rr", -1, 3'b111);
    endtask

    task automatic test_fixed_priority();
        bus.enable = 1'b1;
        bus.priority_mode = 1'b1;
        bus.input_ready = 3'b101;
        do_reset();
        sb_q.delete();
        push_pkt(0, 0);
        push_pkt(0, 4);
        push_pkt(0, 8);
        push_pkt(0, 12);   // already granted when ch0 ready drops
        push_pkt(2, 0);
        consume_contiguous("fixed", 15, 3'b100);
    endtask

    task automatic test_single_channel();
        logic prev = 1'b0;
        int last_rise = -1;
        int run = 0;
        int pulses = 0;
        logic [8:0] e;
        bus.enable = 1'b1;
        bus.priority_mode = 1'b0;
        bus.input_ready = 3'b010;
        do_reset();
        sb_q.delete();
        for (int p = 0; p < 6; p++) push_pkt(1, 4 * p);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.output_valid && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if ({bus.output_sof, bus.output_data} !== e) begin
                    miscompares++;
                    $display("FAIL single_beat cyc %0d: got sof=%b data=%h expected sof=%b data=%h",
                             c, bus.output_sof, bus.output_data, e[8], e[7:0]);
                end
            end
            if (bus.read_req[1] && !prev) begin
                if (last_rise >= 0) begin
                    vectors++;
                    if (c - last_rise != 5) begin
                        miscompares++;
                        $display("FAIL single_period: got %0d cycles expected 5", c - last_rise);
                    end
                end
                last_rise = c;
                run = 0;
            end
            if (bus.read_req[1]) run++;
            if (!bus.read_req[1] && prev) begin
                pulses++;
                vectors++;
                if (run != 4) begin
                    miscompares++;
                    $display("FAIL single_pulse_len: got %0d cycles expected 4", run);
                end
            end
            vectors++;
            if ({bus.read_req[2], bus.read_req[0]} !== 2'b00) begin
                miscompares++;
                $display("FAIL single_other_req cyc %0d: got rr=%b expected only bit 1", c, bus.read_req);
            end
            prev = bus.read_req[1];
        end
        vectors++;
        if (sb_q.size() != 0 || pulses < 6) begin
            miscompares++;
            $display("FAIL single_count: got %0d beats left, %0d pulses expected 0 left, >=6 pulses",
                     sb_q.size(), pulses);
        end
    endtask

    task automatic test_enable_drop();
        int w = 0;
        int nvalid = 0;
        logic [8:0] e;
        bus.enable = 1'b1;
        bus.priority_mode = 1'b0;
        bus.input_ready = 3'b111;
        do_reset();
        sb_q.delete();
        push_pkt(0, 0);
        while (bus.read_req == 3'b000 && w < 12) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (bus.read_req == 3'b000) begin
            miscompares++;
            $display("FAIL en_start: got no read_req within %0d cycles expected a grant", w);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.output_valid) begin
                nvalid++;
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL en_extra_beat cyc %0d: got data=%h expected idle", c, bus.output_data);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.output_sof, bus.output_data} !== e) begin
                        miscompares++;
                        $display("FAIL en_beat cyc %0d: got sof=%b data=%h expected sof=%b data=%h",
                                 c, bus.output_sof, bus.output_data, e[8], e[7:0]);
                    end
                end
            end else begin
                vectors++;
                if (bus.output_data !== 8'hBC) begin
                    miscompares++;
                    $display("FAIL en_idle cyc %0d: got data=%h expected bc", c, bus.output_data);
                end
            end
            if (c == 0) bus.enable = 1'b0;
        end
        vectors++;
        if (nvalid != 5 || bus.read_req !== 3'b000) begin
            miscompares++;
            $display("FAIL en_total: got %0d valid beats rr=%b expected 5 beats rr=000", nvalid, bus.read_req);
        end
    endtask

    task automatic test_reset_midburst();
        int w = 0;
        bus.enable = 1'b1;
        bus.priority_mode = 1'b0;
        bus.input_ready = 3'b111;
        do_reset();
        sb_q.delete();
        while (!bus.output_sof && w < 12) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (!bus.output_sof) begin
            miscompares++;
            $display("FAIL rst_mid_start: got no header within %0d cycles expected one", w);
        end
        @(negedge clk);   // payload 0
        @(negedge clk);   // payload 1
        arst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.output_data, bus.output_valid, bus.output_sof, bus.read_req, bus.active_channel}
            !== {8'hBC, 1'b0, 1'b0, 3'b000, 2'd0}) begin
            miscompares++;
            $display("FAIL rst_mid_values: got data=%h v=%b sof=%b rr=%b act=%0d expected data=bc v=0 sof=0 rr=000 act=0",
                     bus.output_data, bus.output_valid, bus.output_sof, bus.read_req, bus.active_channel);
        end
        arst = 1'b0;
        push_pkt(0, 0);
        consume_contiguous("rst_mid", -1, 3'b111);
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.priority_mode = 1'b0;
        bus.input_ready = 3'b000;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_single_channel();
        test_enable_drop();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000 expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/channel_commutator.md
# channel_commutator

Parametrised successor to the fixed three-channel commutator that sits between the per-channel input buffers and the LVDS serializer. It arbitrates among `CHANNELS` buffers using round-robin or fixed-priority selection. For each granted channel it pulls a burst of `BURST` words, and it emits one framed packet per grant: a header word carrying the channel id, followed by the payload. When no packet is in flight it emits an idle fill word, so the serializer always has data.

## Interface
Parameters:
- `CHANNELS`, 3: number of input buffers; range 2..16.
- `DATA_WIDTH`, 8: word width; must be at least 8.
- `BURST`, 4: payload words per packet; range 1..255.
- `IDLE_WORD`, 8'hBC: fill word, zero-extended to `DATA_WIDTH`.
- `CW`, derived: clog2(`CHANNELS`).

Ports:
- `clk` in 1: single clock; every port is synchronous to it.
- `arst` in 1: synchronous, active-high reset.
- `enable` in 1: allows new grants.
- `priority_mode` in 1: 0 selects round-robin, 1 selects fixed priority (lowest index wins).
- `input_ready` in `CHANNELS`: bit i high means buffer i holds at least `BURST` words.
- `input_data` in `CHANNELS*DATA_WIDTH`: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. Each word is valid the cycle after its `read_req`.
- `read_req` out `CHANNELS`: one-hot pop strobe; registered.
- `output_data` out `DATA_WIDTH`: header, payload or idle word; registered.
- `output_valid` out 1: high on header and payload beats.
- `output_sof` out 1: high on header beats only.
- `active_channel` out `CW`: channel currently granted; holds the last grant while idle.

## Operation
FSM states:
- IDLE: arbitrates.
- READ: pops the granted buffer, using a burst counter from 0 to `BURST`-1.

Transitions:
- IDLE → READ when `enable`=1 and `input_ready` is nonzero. The grant is chosen in that cycle (the grant cycle, G).
- READ → IDLE after `BURST` cycles. IDLE then arbitrates immediately.
- Deasserting `enable` does not abort a burst in progress; it only blocks the next grant.

Arbitration:
- Round-robin: search from (last_grant+1) mod `CHANNELS` upward with wrap-around; the first ready channel wins.
- Fixed priority: the lowest ready index wins. `last_grant` is still updated.
- `priority_mode` is sampled only in IDLE, so changing it mid-burst has no effect until the next arbitration.
- A ready bit that drops during READ is ignored. The buffer contract guarantees `BURST` words are available.

Header word: {4'hA, channel id zero-extended to `DATA_WIDTH`-4}.

Output pipeline: two register stages, tracking which beat type is in flight and the channel it belongs to. The payload mux selects the `input_data` slice of the channel recorded with the beat, not the current grant.

Reset (`arst`=1 at an edge):
- FSM goes to IDLE.
- `read_req`=0, `output_data`=`IDLE_WORD`, `output_valid`=0, `output_sof`=0, `active_channel`=0.
- `last_grant` is set to `CHANNELS`-1, so channel 0 is checked first.
- All pipeline stages are cleared. A packet cut off mid-burst is abandoned; no truncated payload emerges after reset.

## Timing
Relative to grant cycle G:
- `read_req`[g]=1 during cycles G+1 .. G+`BURST`. `active_channel`=g from G+1.
- Header: `output_valid`=1, `output_sof`=1 at G+2.
- Payload word k (k=0..`BURST`-1) appears at G+3+k. It is the word returned for the request issued at G+1+k.
- The earliest next grant is G+`BURST`+1. Its header lands at G+`BURST`+3, immediately after the last payload beat, so back-to-back packets are contiguous.
- Any cycle with no header or payload beat: `output_data`=`IDLE_WORD`, `output_valid`=0.
- Throughput: `BURST`/(`BURST`+1) payload words per cycle under continuous load.

## Test plan
- Reset, defaults, `input_ready`=0 for 20 cycles → `output_data`=8'hBC, `output_valid`=0, `read_req`=0 every cycle.
- `CHANNELS`=3, `BURST`=4, round-robin, all ready permanently, buffers return 0x10+n / 0x20+n / 0x30+n → packets in order ch0, ch1, ch2, ch0. Headers 8'hA0, 8'hA1, 8'hA2. Each header is followed by 4 payload words in order. No idle beats between packets.
- Fixed priority, channels 0 and 2 ready continuously → only channel 0 is served. Drop ch0 ready → next packet header is 8'hA2.
- Only ch1 ready, round-robin → repeated ch1 packets every 5 cycles, each `read_req`[1] pulse exactly 4 cycles long.
- `enable` deasserted 2 cycles into a burst → current packet completes with 5 valid beats, then idle words only.
- `arst` asserted at payload beat 2 → next edge gives all outputs at their reset values. No remaining payload appears. The first post-reset grant goes to channel 0 when all channels are ready.
